instr_encoder_loader: RTL

Encodes symbolic RV32I operations into 32-bit instruction words for exactly the subset the datapath control decodes. Writes the words sequentially into instruction memory through a valid/ready input handshake and a registered single-cycle write port. It sits between the test/boot host and instruction memory, loading a program image before the CPU is released from reset.

---
 rtl/instr_encoder_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//
// Turns symbolic RV32I operations (the subset the datapath decodes) into
// 32-bit instruction words. Each word is written to instruction memory
// through a registered single-cycle write port, filling addresses in order
// from BASE_ADDR. Used by the boot/test host to load a program image
// before the CPU leaves reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous restart (pointer, count, err, full cleared)
//   in_valid   operation fields valid
//   in_ready   block can accept an operation this cycle
//   op         mnemonic code (0-18 legal, 19-31 illegal)
//   rd/rs1/rs2 register indices
//   imm        13-bit signed immediate
//   mem_we     one-cycle write strobe
//   mem_addr   write word address
//   mem_wdata  encoded instruction word
//   count      words written since reset/clear
//   full       memory image full
//   err        sticky error (illegal op or misaligned branch)

module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [12:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    // Count value just before the final word of the image is written.
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - 1);

    typedef enum logic {
        LOAD,
        FULL
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [31:0]           word;
    logic                  legal;
    logic                  accept;
    logic                  do_write;

    assign full     = (state_q == FULL);
    assign in_ready = !full && !clear;
    assign accept   = in_valid && in_ready;
    assign do_write = accept && legal;

    // Instruction encoder. Illegal opcodes and branches with an odd offset
    // are flagged as not legal; they are consumed but never written.
    always_comb begin
        word  = 32'd0;
        legal = 1'b1;
        case (op)
            5'd0:  word = {7'h00, rs2, rs1, 3'd0, rd, 7'b0110011};
            5'd1:  word = {7'h20, rs2, rs1, 3'd0, rd, 7'b0110011};
            5'd2:  word = {7'h00, rs2, rs1, 3'd4, rd, 7'b0110011};
            5'd3:  word = {7'h00, rs2, rs1, 3'd6, rd, 7'b0110011};
            5'd4:  word = {7'h00, rs2, rs1, 3'd7, rd, 7'b0110011};
            5'd5:  word = {7'h00, rs2, rs1, 3'd1, rd, 7'b0110011};
            5'd6:  word = {7'h00, rs2, rs1, 3'd5, rd, 7'b0110011};
            5'd7:  word = {imm[11:0], rs1, 3'd0, rd, 7'b0010011};
            5'd8:  word = {imm[11:0], rs1, 3'd4, rd, 7'b0010011};
            5'd9:  word = {imm[11:0], rs1, 3'd6, rd, 7'b0010011};
            5'd10: word = {imm[11:0], rs1, 3'd7, rd, 7'b0010011};
            // Shifts carry only the 5-bit shamt; upper immediate bits are zero.
            5'd11: word = {7'h00, imm[4:0], rs1, 3'd1, rd, 7'b0010011};
            5'd12: word = {7'h00, imm[4:0], rs1, 3'd5, rd, 7'b0010011};
            5'd13: word = {imm[11:0], rs1, 3'd2, rd, 7'b0000011};
            5'd14: word = {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
            5'd15: word = {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], 7'b1100011};
            5'd16: word = {imm[12], imm[10:5], rs2, rs1, 3'd1, imm[4:1], imm[11], 7'b1100011};
            5'd17: word = {imm[12], imm[10:5], rs2, rs1, 3'd4, imm[4:1], imm[11], 7'b1100011};
            5'd18: word = {imm[12], imm[10:5], rs2, rs1, 3'd5, imm[4:1], imm[11], 7'b1100011};
            default: legal = 1'b0;
        endcase
        // Branch targets must be halfword aligned.
        if ((op >= 5'd15) && (op <= 5'd18) && imm[0]) begin
            legal = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the last write of the image moves to FULL, clear returns to LOAD.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (do_write && (count == LAST_COUNT)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (clear) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Write port, pointer, count and sticky error. clear wins over any
    // write that would otherwise be registered this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= BASE;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= 32'd0;
        end else if (clear) begin
            ptr      <= BASE;
            count    <= '0;
            err      <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= BASE;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr  <= ptr;
                mem_wdata <= word;
                ptr       <= ptr + 1'b1;
                count     <= count + 1'b1;
            end
            if (accept && !legal) begin
                err <= 1'b1;
            end
        end
    end

endmodule
